// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI slave shifter.
//   state_e    - frame FSM state (IDLE between frames, SHIFT inside a frame)
//   MAX_W      - shift/holding register width
//   W8, W16    - the two supported word widths
//   tx_bit()   - selects the bit a word presents on miso for a given width/order
package spi_slave_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned MAX_W = 16;
  localparam int unsigned W8    = 8;
  localparam int unsigned W16   = 16;

  // Leading bit of a word: bit W-1 for MSB-first, bit 0 for LSB-first.
  function automatic logic tx_bit(logic [MAX_W-1:0] word, logic wide, logic lsb);
    if (lsb) begin
      return word[0];
    end
    return wide ? word[W16-1] : word[W8-1];
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: 5-bit count of sampled bits within the current word.
//   clk, rst_n - system clock, asynchronous active-low reset
//   clr        - synchronous clear (frame not active / frame ended)
//   inc        - one sample edge
//   width16    - word width select: 0 = 8 bit, 1 = 16 bit
//   tc         - terminal count: the next inc completes the word
// The count wraps to 0 on the increment that reaches W, so it never holds W.
module spi_bit_counter
  import spi_slave_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic width16,
  output logic tc
);

  logic [4:0] cnt_q;

  assign tc = (cnt_q == (width16 ? 5'(W16 - 1) : 5'(W8 - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (inc && tc)) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI slave data path driven by pre-detected sck edge pulses.
//   clk, rst_n       - system clock, asynchronous active-low reset
//   cpha             - 0: sample on first edge, 1: sample on second edge
//   spi_width        - 0: 8-bit words, 1: 16-bit words (latched at spi_start)
//   sck_first_edge   - one-clk pulse per leading sck edge
//   sck_second_edge  - one-clk pulse per trailing sck edge
//   spi_start        - one-clk pulse on cs falling
//   spi_finish       - one-clk pulse on cs rising
//   mosi             - synchronised serial input
//   lsb_first        - (SPI_SLAVE_LSB_FIRST_EN only) bit order, latched at spi_start
//   miso             - serial output, MISO_IDLE outside a frame
//   tx_data/valid    - write into the TX holding register
//   tx_ready         - holding register empty
//   rx_data/valid    - last complete received word, one-clk valid pulse
// Optional feature macro: SPI_SLAVE_LSB_FIRST_EN adds the lsb_first input.
module spi_slave_shifter #(
  parameter int unsigned MAX_W     = spi_slave_pkg::MAX_W,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpha,
  input  logic             spi_width,
  input  logic             sck_first_edge,
  input  logic             sck_second_edge,
  input  logic             spi_start,
  input  logic             spi_finish,
  input  logic             mosi,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic             lsb_first,
`endif
  output logic             miso,
  input  logic [MAX_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [MAX_W-1:0] rx_data,
  output logic             rx_valid
);

  import spi_slave_pkg::*;

  state_e           state_q;
  logic             wide_q;
  logic             pend_q;    // next launch presents the loaded word's first bit unshifted
  logic [MAX_W-1:0] rx_sr_q;
  logic [MAX_W-1:0] tx_sr_q;
  logic [MAX_W-1:0] hold_q;
  logic [MAX_W-1:0] rx_data_q;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic             miso_q;

  logic             in_shift;
  logic             sample;
  logic             launch;
  logic             tc;
  logic             word_done;
  logic             start_ok;
  logic             cnt_clr;
  logic             lsb_start;
  logic             lsb_frame;
  logic [MAX_W-1:0] load_val;
  logic [MAX_W-1:0] rx_nxt;
  logic [MAX_W-1:0] tx_shift;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_q;
  assign lsb_start = lsb_first;
  assign lsb_frame = lsb_q;
`else
  assign lsb_start = 1'b0;
  assign lsb_frame = 1'b0;
`endif

  assign in_shift  = (state_q == SHIFT);
  assign sample    = in_shift && (cpha ? sck_second_edge : sck_first_edge);
  assign launch    = in_shift && (cpha ? sck_first_edge : sck_second_edge);
  assign word_done = sample && tc;
  // spi_finish wins over a coincident spi_start.
  assign start_ok  = (state_q == IDLE) && spi_start && !spi_finish;
  assign cnt_clr   = !in_shift || spi_finish;
  // Underrun sends zeros.
  assign load_val  = tx_ready_q ? '0 : hold_q;
  assign tx_shift  = lsb_frame ? (tx_sr_q >> 1) : (tx_sr_q << 1);

  always_comb begin
    rx_nxt = '0;
    if (lsb_frame) begin
      rx_nxt = rx_sr_q >> 1;
      if (wide_q) begin
        rx_nxt[W16-1] = mosi;
      end else begin
        rx_nxt[W8-1] = mosi;
      end
    end else begin
      rx_nxt = {rx_sr_q[MAX_W-2:0], mosi};
      if (!wide_q) begin
        rx_nxt[MAX_W-1:W8] = '0;
      end
    end
  end

  spi_bit_counter u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (sample),
    .width16 (wide_q),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wide_q     <= 1'b0;
      pend_q     <= 1'b0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      miso_q     <= MISO_IDLE;
`ifdef SPI_SLAVE_LSB_FIRST_EN
      lsb_q      <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;

      // Write and consume are exclusive: write needs empty, consume needs full.
      if (tx_valid && tx_ready_q) begin
        hold_q     <= tx_data;
        tx_ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= SHIFT;
            wide_q  <= spi_width;
`ifdef SPI_SLAVE_LSB_FIRST_EN
            lsb_q   <= lsb_first;
`endif
            tx_sr_q <= load_val;
            miso_q  <= tx_bit(load_val, spi_width, lsb_start);
            // cpha=0 already shows the first bit; cpha=1 shows it on the first launch.
            pend_q  <= cpha;
            rx_sr_q <= '0;
            if (!tx_ready_q) begin
              tx_ready_q <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (sample) begin
            if (tc) begin
              rx_data_q  <= rx_nxt;
              rx_valid_q <= 1'b1;
              rx_sr_q    <= '0;
            end else begin
              rx_sr_q <= rx_nxt;
            end
          end

          if (launch) begin
            if (pend_q) begin
              miso_q <= tx_bit(tx_sr_q, wide_q, lsb_frame);
              pend_q <= 1'b0;
            end else begin
              tx_sr_q <= tx_shift;
              miso_q  <= tx_bit(tx_shift, wide_q, lsb_frame);
            end
          end

          if (spi_finish) begin
            // A word completing on this same clk still reports above.
            state_q <= IDLE;
            miso_q  <= MISO_IDLE;
            pend_q  <= 1'b0;
            rx_sr_q <= '0;
          end else if (word_done) begin
            // Next word of the frame; the following launch edge must not shift it.
            tx_sr_q <= load_val;
            miso_q  <= tx_bit(load_val, wide_q, lsb_frame);
            pend_q  <= 1'b1;
            if (!tx_ready_q) begin
              tx_ready_q <= 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: directed SPI slave frames with a scoreboard on rx_valid.
// The driver plays the SPI master (edge pulses, mosi, miso capture) and pushes the
// expected receive words; the monitor pops one per rx_valid cycle.
module tb_spi_slave_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpha = 1'b0;
  logic        spi_width = 1'b0;
  logic        sck_first_edge = 1'b0;
  logic        sck_second_edge = 1'b0;
  logic        spi_start = 1'b0;
  logic        spi_finish = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_rx = 0;
  int          exp_rx_count = 0;
  logic [15:0] exp_q[$];
  logic        last_rv;

  spi_slave_shifter #(
    .MAX_W     (16),
    .MISO_IDLE (1'b0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpha            (cpha),
    .spi_width       (spi_width),
    .sck_first_edge  (sck_first_edge),
    .sck_second_edge (sck_second_edge),
    .spi_start       (spi_start),
    .spi_finish      (spi_finish),
    .mosi            (mosi),
    .miso            (miso),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data %h, expected no word", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [15:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic start_frame(input logic ph, input logic wide);
    cpha      = ph;
    spi_width = wide;
    spi_start = 1'b1;
    @(negedge clk);
    spi_start = 1'b0;
    idle(1);
  endtask

  task automatic finish_frame();
    spi_finish = 1'b1;
    @(negedge clk);
    spi_finish = 1'b0;
    idle(2);
  endtask

  // One master bit: drive mosi, capture miso just before the sample edge.
  task automatic xfer_bit(input logic b, input logic fin, output logic m);
    if (!cpha) begin
      mosi = b;
      m = miso;
      sck_first_edge = 1'b1;
      spi_finish = fin;
      @(negedge clk);
      sck_first_edge = 1'b0;
      spi_finish = 1'b0;
      last_rv = rx_valid;
      if (!fin) begin
        idle(1);
        sck_second_edge = 1'b1;
        @(negedge clk);
        sck_second_edge = 1'b0;
        idle(1);
      end
    end else begin
      sck_first_edge = 1'b1;
      @(negedge clk);
      sck_first_edge = 1'b0;
      idle(1);
      mosi = b;
      m = miso;
      sck_second_edge = 1'b1;
      spi_finish = fin;
      @(negedge clk);
      sck_second_edge = 1'b0;
      spi_finish = 1'b0;
      last_rv = rx_valid;
      idle(1);
    end
  endtask

  task automatic send_word(input logic [15:0] mo, input int nbits, input int mid_at,
                           input logic [15:0] mid_val, input logic fin_last,
                           output logic [15:0] mi);
    int   w;
    logic m;
    w  = spi_width ? 16 : 8;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == mid_at) write_tx(mid_val);
      xfer_bit(mo[w-1-i], fin_last && (i == nbits - 1), m);
      mi = {mi[14:0], m};
    end
  endtask

  task automatic expect_rx(input logic [15:0] v);
    exp_q.push_back(v);
    exp_rx_count++;
  endtask

  logic [15:0] mi;

  initial begin
    idle(2);
    #1;
    check("reset_tx_ready", {15'd0, tx_ready}, 16'd1);
    check("reset_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("reset_rx_data", rx_data, 16'h0000);
    check("reset_miso", {15'd0, miso}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // cpha=0, 8 bit, tx A5, master sends 3C.
    write_tx(16'h00A5);
    check("tx_ready_after_write", {15'd0, tx_ready}, 16'd0);
    start_frame(1'b0, 1'b0);
    check("cpha0_first_bit_before_sck", {15'd0, miso}, 16'd1);
    check("tx_ready_after_start", {15'd0, tx_ready}, 16'd1);
    expect_rx(16'h003C);
    send_word(16'h003C, 8, -1, '0, 1'b0, mi);
    check("cpha0_miso_word", mi, 16'h00A5);
    check("cpha0_rx_valid_timing", {15'd0, last_rv}, 16'd1);
    finish_frame();

    // cpha=1, 16 bit, tx 8001, master sends 1234.
    write_tx(16'h8001);
    start_frame(1'b1, 1'b1);
    expect_rx(16'h1234);
    send_word(16'h1234, 16, -1, '0, 1'b0, mi);
    check("cpha1_first_launch_msb", {15'd0, mi[15]}, 16'd1);
    check("cpha1_miso_word", mi, 16'h8001);
    check("cpha1_rx_valid_timing", {15'd0, last_rv}, 16'd1);
    check("cpha1_rx_data_timing", rx_data, 16'h1234);
    finish_frame();

    // Two 8-bit words in one frame, second tx word written mid word 1.
    write_tx(16'h005A);
    start_frame(1'b0, 1'b0);
    expect_rx(16'h0011);
    send_word(16'h0011, 8, 4, 16'h00C3, 1'b0, mi);
    check("b2b_word1_miso", mi, 16'h005A);
    expect_rx(16'h00EE);
    send_word(16'h00EE, 8, -1, '0, 1'b0, mi);
    check("b2b_word2_miso", mi, 16'h00C3);
    check("b2b_tx_ready", {15'd0, tx_ready}, 16'd1);
    finish_frame();

    // Underrun.
    start_frame(1'b0, 1'b0);
    expect_rx(16'h00A7);
    send_word(16'h00A7, 8, -1, '0, 1'b0, mi);
    check("underrun_miso", mi, 16'h0000);
    check("underrun_tx_ready", {15'd0, tx_ready}, 16'd1);
    finish_frame();

    // Partial word discarded; holding register survives the finish.
    write_tx(16'h00E1);
    start_frame(1'b0, 1'b0);
    send_word(16'h00FF, 5, 2, 16'h003C, 1'b0, mi);
    finish_frame();
    check("partial_miso_idle", {15'd0, miso}, 16'd0);
    check("partial_hold_kept", {15'd0, tx_ready}, 16'd0);
    start_frame(1'b0, 1'b0);
    expect_rx(16'h0096);
    send_word(16'h0096, 8, -1, '0, 1'b0, mi);
    check("after_partial_miso", mi, 16'h003C);
    finish_frame();

    // W-th sample coincides with spi_finish.
    write_tx(16'h000F);
    start_frame(1'b0, 1'b0);
    expect_rx(16'h0081);
    send_word(16'h0081, 8, -1, '0, 1'b1, mi);
    check("finish_on_last_rx_valid", {15'd0, last_rv}, 16'd1);
    check("finish_on_last_miso", mi, 16'h000F);
    idle(2);
    check("finish_on_last_idle", {15'd0, miso}, 16'd0);

    // spi_start with spi_finish: stays IDLE, edges ignored, holding not consumed.
    write_tx(16'h006D);
    spi_start  = 1'b1;
    spi_finish = 1'b1;
    @(negedge clk);
    spi_start  = 1'b0;
    spi_finish = 1'b0;
    idle(1);
    check("start_finish_hold_kept", {15'd0, tx_ready}, 16'd0);
    send_word(16'h00FF, 8, -1, '0, 1'b0, mi);
    check("start_finish_miso_idle", {15'd0, miso}, 16'd0);
    start_frame(1'b0, 1'b0);
    expect_rx(16'h0042);
    send_word(16'h0042, 8, -1, '0, 1'b0, mi);
    check("start_finish_next_miso", mi, 16'h006D);
    finish_frame();

    // Reset mid-frame after 3 bits.
    write_tx(16'h0099);
    start_frame(1'b0, 1'b0);
    send_word(16'h00FF, 3, -1, '0, 1'b0, mi);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_ready", {15'd0, tx_ready}, 16'd1);
    check("midrst_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("midrst_rx_data", rx_data, 16'h0000);
    check("midrst_miso", {15'd0, miso}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_word(16'h00FF, 8, -1, '0, 1'b0, mi);
    check("postrst_idle_miso", {15'd0, miso}, 16'd0);
    write_tx(16'hBEEF);
    start_frame(1'b1, 1'b1);
    expect_rx(16'hCAFE);
    send_word(16'hCAFE, 16, -1, '0, 1'b0, mi);
    check("postrst_miso_word", mi, 16'hBEEF);
    finish_frame();

    idle(4);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    check("rx_valid_count", 16'(n_rx), 16'(exp_rx_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
